melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1200000, clk_in cycles per duration tick (100 ms at 12 MHz); legal minimum 2.
REQ-002 Parameter GAP_TICKS, default 1, silent ticks inserted after every played note or rest; legal range 0-15.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 play_start  input  1  single-cycle pulse; starts playback from ROM address 0.
REQ-006 play_stop  input  1  single-cycle pulse; aborts playback.
REQ-007 loop_en  input  1  level; on end marker, restart at address 0 instead of stopping.
REQ-008 key_in  input  16  live keyboard, already synchronized; any bit set means a key request.
REQ-009 rom_addr  output  5  song ROM address, registered.
REQ-010 rom_data  input  8  song ROM word, combinational read of rom_addr: [7:4] note code, [3:0] duration.
REQ-011 tone  output  16  one-hot tone select to the beeper, registered; all-zero when silent.
REQ-012 tone_en  output  1  beeper enable, registered.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  single-cycle pulse on normal song completion.

Function
REQ-015 FSM states: IDLE, FETCH, NOTE, GAP; reset state IDLE.
REQ-016 IDLE -> FETCH on play_start; rom_addr cleared to 0 on that edge.
REQ-017 FETCH lasts exactly 1 cycle; rom_data is sampled at its end into note and duration registers.
REQ-018 Note code 15 is the end marker: loop_en=1 -> rom_addr=0 then FETCH; loop_en=0 -> IDLE with done=1 for 1 cycle.
REQ-019 Note code 0 is a rest; codes 1-14 select tone bit (code-1).
REQ-020 Duration field 0 means 16 ticks; values 1-15 are literal tick counts.
REQ-021 NOTE lasts exactly duration*TICK_DIV cycles; tick and cycle counters are cleared on entry to NOTE and to GAP.
REQ-022 NOTE -> GAP when GAP_TICKS>0, otherwise straight to FETCH; GAP lasts GAP_TICKS*TICK_DIV cycles, then FETCH.
REQ-023 On leaving NOTE/GAP for FETCH, rom_addr increments modulo 32 (31 -> 0, playback continues).
REQ-024 Source select: key_in nonzero has priority; tone = lowest set bit of key_in only, tone_en=1.
REQ-025 While key_in nonzero, tick/cycle counters and FSM are frozen in any state; they resume on the cycle key_in returns to 0.
REQ-026 With key_in zero: in NOTE with codes 1-14, tone = sequencer tone and tone_en=1; otherwise tone=0 and tone_en=0.
REQ-027 tone and tone_en are registered one cycle after the source condition.
REQ-028 play_stop from any non-IDLE state -> IDLE on the next edge, rom_addr=0, no done pulse; key requests still pass through.
REQ-029 play_start while busy is ignored; play_start and play_stop together -> stop wins.
REQ-030 Key requests are honoured in IDLE as well; the FSM stays in IDLE.

Reset
REQ-031 While rst_n_in=0: state IDLE, rom_addr=0, tone=0, tone_en=0, busy=0, done=0, all counters 0.
REQ-032 Reset asserted mid-note silences tone_en asynchronously; no playback resumes after release without a new play_start.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-033 ROM[0]=8'h12, ROM[1]=8'hF0, play_start -> tone=16'h0001 with tone_en=1 for 8 cycles, 4 silent gap cycles, end marker fetched, done pulse, busy=0.
REQ-034 Same ROM, loop_en=1 -> rom_addr returns to 0 after the marker and tone 16'h0001 repeats; play_stop -> busy=0 next cycle, tone_en=0 one cycle later, no done pulse.
REQ-035 ROM[0]=8'h00 (rest, 16 ticks) -> tone_en stays 0 for 64 cycles plus 4 gap cycles, then FETCH of address 1.
REQ-036 Mid-note, key_in=16'h0028 for 10 cycles -> tone=16'h0008, tone_en=1; after release, the song note resumes with its remaining cycles unchanged.
REQ-037 All 32 ROM words hold 8'h31 with loop_en=0 -> rom_addr wraps 31 -> 0, no done pulse, playback continues; play_start while busy does not restart it.
REQ-038 rst_n_in pulsed low mid-NOTE -> all outputs 0 immediately; FSM idle after release.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// Control, song-ROM and beeper signals of the melody sequencer, grouped as one bus.
interface melody_sequencer_if;
    logic        play_start;
    logic        play_stop;
    logic        loop_en;
    logic [15:0] key_in;
    logic [4:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] tone;
    logic        tone_en;
    logic        busy;
    logic        done;

    modport slave (
        input  play_start, play_stop, loop_en, key_in, rom_data,
        output rom_addr, tone, tone_en, busy, done
    );

    modport master (
        output play_start, play_stop, loop_en, key_in, rom_data,
        input  rom_addr, tone, tone_en, busy, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// ROM-driven melody player with a live keyboard override that freezes song timing.
module melody_sequencer #(
    parameter int TICK_DIV  = 1200000,
    parameter int GAP_TICKS = 1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    melody_sequencer_if.slave  bus
);
    localparam int             CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CYC_LAST = CW'(TICK_DIV - 1);
    localparam logic [4:0]     GAP_LAST = 5'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, NOTE, GAP} state_t;

    state_t         r_state, w_state_nxt;
    logic [4:0]     r_addr, w_addr_nxt;
    logic [CW-1:0]  r_cyc, w_cyc_nxt;
    logic [4:0]     r_tick, w_tick_nxt;
    logic [3:0]     r_note, w_note_nxt;
    logic [4:0]     r_dur, w_dur_nxt;
    logic           r_done, w_done_nxt;
    logic [15:0]    r_tone, w_tone_src;
    logic           r_tone_en, w_en_src;
    logic           w_key_act;
    logic           w_cyc_last;

    assign w_key_act  = |bus.key_in;
    assign w_cyc_last = (r_cyc == CYC_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cyc     <= '0;
            r_tick    <= '0;
            r_note    <= '0;
            r_dur     <= '0;
            r_done    <= 1'b0;
            r_tone    <= '0;
            r_tone_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cyc     <= w_cyc_nxt;
            r_tick    <= w_tick_nxt;
            r_note    <= w_note_nxt;
            r_dur     <= w_dur_nxt;
            r_done    <= w_done_nxt;
            r_tone    <= w_tone_src;
            r_tone_en <= w_en_src;
        end
    end

    // Stop beats the keyboard freeze; everything else waits while a key is held.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cyc_nxt   = r_cyc;
        w_tick_nxt  = r_tick;
        w_note_nxt  = r_note;
        w_dur_nxt   = r_dur;
        w_done_nxt  = 1'b0;
        if (bus.play_stop && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
            w_cyc_nxt   = '0;
            w_tick_nxt  = '0;
        end else if (!w_key_act) begin
            case (r_state)
                IDLE: begin
                    if (bus.play_start && !bus.play_stop) begin
                        w_state_nxt = FETCH;
                        w_addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    if (bus.rom_data[7:4] == 4'hF) begin
                        if (bus.loop_en) begin
                            w_addr_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_note_nxt  = bus.rom_data[7:4];
                        w_dur_nxt   = (bus.rom_data[3:0] == 4'd0) ? 5'd16 : {1'b0, bus.rom_data[3:0]};
                        w_state_nxt = NOTE;
                        w_cyc_nxt   = '0;
                        w_tick_nxt  = '0;
                    end
                end
                NOTE: begin
                    w_cyc_nxt = w_cyc_last ? '0 : r_cyc + 1'b1;
                    if (w_cyc_last) begin
                        if (r_tick == r_dur - 5'd1) begin
                            w_tick_nxt = '0;
                            if (GAP_TICKS != 0) begin
                                w_state_nxt = GAP;
                            end else begin
                                w_state_nxt = FETCH;
                                w_addr_nxt  = r_addr + 5'd1;
                            end
                        end else begin
                            w_tick_nxt = r_tick + 5'd1;
                        end
                    end
                end
                GAP: begin
                    w_cyc_nxt = w_cyc_last ? '0 : r_cyc + 1'b1;
                    if (w_cyc_last) begin
                        if (r_tick == GAP_LAST) begin
                            w_tick_nxt  = '0;
                            w_state_nxt = FETCH;
                            w_addr_nxt  = r_addr + 5'd1;
                        end else begin
                            w_tick_nxt = r_tick + 5'd1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Keyboard wins; x & -x isolates its lowest set bit.
    always_comb begin
        w_tone_src = '0;
        w_en_src   = 1'b0;
        if (w_key_act) begin
            w_tone_src = bus.key_in & (~bus.key_in + 16'd1);
            w_en_src   = 1'b1;
        end else if (r_state == NOTE && r_note != 4'd0) begin
            w_tone_src = 16'd1 << (r_note - 4'd1);
            w_en_src   = 1'b1;
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.tone     = r_tone;
    assign bus.tone_en  = r_tone_en;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed checks of melody_sequencer with TICK_DIV=4, GAP_TICKS=1.
module tb_melody_sequencer;
    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    melody_sequencer_if bus();
    logic [7:0] rom [32];
    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    always #5 clk_in = ~clk_in;

    assign bus.rom_data = rom[bus.rom_addr];

    melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always @(negedge clk_in) if (bus.done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_pulse();
        bus.play_start = 1'b1;
        step();
        bus.play_start = 1'b0;
    endtask

    task automatic wait_tone(input string tag);
        for (int k = 0; k < 200 && !bus.tone_en; k++) step();
        chk(tag, bus.tone_en, 1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && !bus.done; k++) step();
        chk(tag, bus.done, 1);
    endtask

    initial begin
        int hi, lo, k, base, en_seen;
        bus.play_start = 0; bus.play_stop = 0; bus.loop_en = 0; bus.key_in = '0;
        for (int i = 0; i < 32; i++) rom[i] = 8'hF0;
        rom[0] = 8'h12; rom[1] = 8'hF0;
        step(); step();
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_tone", bus.tone, 0);
        chk("rst_en", bus.tone_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n_in = 1'b1;
        step();

        // single note then end marker
        start_pulse();
        chk("t1_busy", bus.busy, 1);
        step();
        chk("t1_en_lat", bus.tone_en, 0);
        step();
        chk("t1_tone", bus.tone, 16'h0001);
        hi = 0;
        while (bus.tone_en && hi < 50) begin hi++; step(); end
        chk("t1_hi_cyc", hi, 8);
        lo = 0;
        while (!bus.done && lo < 50) begin lo++; step(); end
        chk("t1_gap_cyc", lo, 4);
        chk("t1_done", bus.done, 1);
        chk("t1_addr", bus.rom_addr, 1);
        step();
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_idle", bus.busy, 0);

        // loop then stop
        base = n_done;
        bus.loop_en = 1'b1;
        start_pulse();
        wait_tone("t2_first");
        while (bus.tone_en) step();
        wait_tone("t2_repeat");
        chk("t2_tone", bus.tone, 16'h0001);
        chk("t2_addr", bus.rom_addr, 0);
        bus.play_stop = 1'b1;
        step();
        bus.play_stop = 1'b0;
        chk("t2_stop_busy", bus.busy, 0);
        chk("t2_stop_en_hold", bus.tone_en, 1);
        step();
        chk("t2_stop_en", bus.tone_en, 0);
        chk("t2_stop_addr", bus.rom_addr, 0);
        chk("t2_no_done", n_done - base, 0);
        bus.loop_en = 1'b0;

        // 16-tick rest
        rom[0] = 8'h00;
        start_pulse();
        k = 0; en_seen = 0;
        while (bus.rom_addr != 5'd1 && k < 200) begin
            step(); k++;
            if (bus.tone_en) en_seen = 1;
        end
        chk("t3_rest_cyc", k, 69);
        chk("t3_silent", en_seen, 0);
        chk("t3_busy", bus.busy, 1);
        wait_done("t3_done");

        // keyboard freeze mid-note
        rom[0] = 8'h34;
        step();
        start_pulse();
        wait_tone("t4_note");
        chk("t4_tone", bus.tone, 16'h0004);
        step(); step();
        bus.key_in = 16'h0028;
        step();
        chk("t4_key_tone", bus.tone, 16'h0008);
        repeat (9) step();
        chk("t4_key_hold", bus.tone, 16'h0008);
        chk("t4_key_busy", bus.busy, 1);
        bus.key_in = '0;
        hi = 0;
        step();
        while (bus.tone_en && bus.tone == 16'h0004 && hi < 50) begin hi++; step(); end
        chk("t4_remain", hi, 13);
        wait_done("t4_done");
        step();

        // keyboard in IDLE, and start+stop together
        bus.key_in = 16'h8000;
        step();
        chk("t5_idle_key", bus.tone, 16'h8000);
        chk("t5_idle_en", bus.tone_en, 1);
        chk("t5_idle_busy", bus.busy, 0);
        bus.key_in = '0;
        step();
        chk("t5_idle_rel", bus.tone_en, 0);
        bus.play_start = 1'b1; bus.play_stop = 1'b1;
        step();
        bus.play_start = 1'b0; bus.play_stop = 1'b0;
        chk("t5_stop_wins", bus.busy, 0);

        // address wrap, restart ignored while busy
        for (int i = 0; i < 32; i++) rom[i] = 8'h31;
        base = n_done;
        start_pulse();
        k = 0;
        while (bus.rom_addr != 5'd5 && k < 200) begin step(); k++; end
        chk("t6_addr5", bus.rom_addr, 5);
        start_pulse();
        step();
        chk("t6_no_restart", bus.rom_addr, 5);
        k = 0;
        while (bus.rom_addr != 5'd31 && k < 400) begin step(); k++; end
        chk("t6_addr31", bus.rom_addr, 31);
        k = 0;
        while (bus.rom_addr == 5'd31 && k < 20) begin step(); k++; end
        chk("t6_wrap", bus.rom_addr, 0);
        chk("t6_wrap_busy", bus.busy, 1);
        wait_tone("t6_wrap_tone");
        chk("t6_no_done", n_done - base, 0);
        bus.play_stop = 1'b1;
        step();
        bus.play_stop = 1'b0;
        step();

        // asynchronous reset mid-note
        rom[0] = 8'h34;
        start_pulse();
        wait_tone("t7_note");
        #3 rst_n_in = 1'b0;
        #1;
        chk("t7_rst_en", bus.tone_en, 0);
        chk("t7_rst_tone", bus.tone, 0);
        chk("t7_rst_busy", bus.busy, 0);
        chk("t7_rst_addr", bus.rom_addr, 0);
        step();
        rst_n_in = 1'b1;
        repeat (5) step();
        chk("t7_post_busy", bus.busy, 0);
        chk("t7_post_en", bus.tone_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
